// File: rtl/reg_file_param_pkg.sv
// Shared defaults and the pending-count helper for the parameterised register file.
package reg_file_param_pkg;

   localparam int DEF_DATA_W = 32;
   localparam int DEF_ADDR_W = 5;

   // Two's-complement change in the pending population: +set_new, -clr_a, -clr_b.
   function automatic logic [2:0] busy_delta(input logic set_new,
                                             input logic clr_a,
                                             input logic clr_b);
      logic [2:0] inc;
      logic [2:0] dec;
      inc = {2'b00, set_new};
      dec = {2'b00, clr_a} + {2'b00, clr_b};
      return inc - dec;
   endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-writeback scoreboard: one bit per register plus a registered population count.
module reg_scoreboard
   import reg_file_param_pkg::*;
#(
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter bit ZERO_R0 = 1'b1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   iss_en,
   input  logic [ADDR_W-1:0]      iss_addr,
   input  logic                   wr_en0,
   input  logic [ADDR_W-1:0]      wr_addr0,
   input  logic                   wr_en1,
   input  logic [ADDR_W-1:0]      wr_addr1,
   output logic [2**ADDR_W-1:0]   pending,
   output logic [ADDR_W:0]        busy_cnt
);

   localparam int NUM_REGS = 2**ADDR_W;

   logic [NUM_REGS-1:0] pend_q;
   logic [NUM_REGS-1:0] pend_d;
   logic [ADDR_W:0]     cnt_q;
   logic [ADDR_W:0]     cnt_d;
   logic                set_ok;
   logic                set_new;
   logic                clr0;
   logic                clr1;
   logic [2:0]          delta;

   // NOTE: every variable gets a full default before any conditional update, so no latch is inferred.
   always_comb begin
      set_ok  = iss_en && !(ZERO_R0 && iss_addr == '0);
      set_new = set_ok && !pend_q[iss_addr];
      // A clear only counts if the bit is set, not re-set by an issue, and not already counted by port 0.
      clr0    = wr_en0 && pend_q[wr_addr0] && !(set_ok && iss_addr == wr_addr0);
      clr1    = wr_en1 && pend_q[wr_addr1] && !(set_ok && iss_addr == wr_addr1)
                && !(wr_en0 && wr_addr0 == wr_addr1);
      delta   = busy_delta(set_new, clr0, clr1);

      pend_d = pend_q;
      if (wr_en0) pend_d[wr_addr0] = 1'b0;
      if (wr_en1) pend_d[wr_addr1] = 1'b0;
      if (set_ok) pend_d[iss_addr] = 1'b1;

      cnt_d = cnt_q + (ADDR_W+1)'($signed(delta));
   end

   // NOTE: state is updated with <= so every flop samples the pre-edge values of the others.
   always_ff @(posedge clk) begin
      if (rst) begin
         pend_q <= '0;
         cnt_q  <= '0;
      end else begin
         pend_q <= pend_d;
         cnt_q  <= cnt_d;
      end
   end

   assign pending  = pend_q;
   assign busy_cnt = cnt_q;

endmodule

// File: rtl/reg_file_param.sv
// Multi-port register file with two write ports, same-cycle bypass and a writeback scoreboard.
module reg_file_param
   import reg_file_param_pkg::*;
#(
   parameter int DATA_W  = DEF_DATA_W,
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int NUM_RD  = 2,
   parameter bit ZERO_R0 = 1'b1,
   parameter bit BYPASS  = 1'b1
) (
   input  logic                       SYS_clk,
   input  logic                       SYS_reset,
   input  logic [NUM_RD*ADDR_W-1:0]   REG_rd_addr,
   output logic [NUM_RD*DATA_W-1:0]   REG_rd_data,
   output logic [NUM_RD-1:0]          REG_rd_busy,
   input  logic                       REG_wr_en0,
   input  logic [ADDR_W-1:0]          REG_wr_addr0,
   input  logic [DATA_W-1:0]          REG_wr_data0,
   input  logic                       REG_wr_en1,
   input  logic [ADDR_W-1:0]          REG_wr_addr1,
   input  logic [DATA_W-1:0]          REG_wr_data1,
   input  logic                       REG_iss_en,
   input  logic [ADDR_W-1:0]          REG_iss_addr,
   output logic [ADDR_W:0]            REG_busy_cnt
);

   localparam int NUM_REGS = 2**ADDR_W;

   logic [DATA_W-1:0]   regs_q [NUM_REGS];
   logic [DATA_W-1:0]   regs_d [NUM_REGS];
   logic [NUM_REGS-1:0] pending;
   logic                wr_ok0;
   logic                wr_ok1;

   always_comb begin
      wr_ok0 = REG_wr_en0 && !(ZERO_R0 && REG_wr_addr0 == '0);
      wr_ok1 = REG_wr_en1 && !(ZERO_R0 && REG_wr_addr1 == '0);
      regs_d = regs_q;
      if (wr_ok0) regs_d[REG_wr_addr0] = REG_wr_data0;
      // Port 1 is applied last so it wins a same-address collision.
      if (wr_ok1) regs_d[REG_wr_addr1] = REG_wr_data1;
   end

   // NOTE: every register must clear on reset, so the array is built from flops rather than an inferred RAM.
   always_ff @(posedge SYS_clk) begin
      if (SYS_reset) regs_q <= '{default: '0};
      else           regs_q <= regs_d;
   end

   for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
      logic [ADDR_W-1:0] addr;
      logic              hit0;
      logic              hit1;
      logic [DATA_W-1:0] data;

      always_comb begin
         addr = REG_rd_addr[k*ADDR_W +: ADDR_W];
         hit0 = BYPASS && REG_wr_en0 && REG_wr_addr0 == addr;
         hit1 = BYPASS && REG_wr_en1 && REG_wr_addr1 == addr;
         if (ZERO_R0 && addr == '0) data = '0;
         else if (hit1)             data = REG_wr_data1;
         else if (hit0)             data = REG_wr_data0;
         else                       data = regs_q[addr];
      end

      assign REG_rd_data[k*DATA_W +: DATA_W] = data;
      // A register being written back this cycle is not busy to a bypassing reader.
      assign REG_rd_busy[k] = pending[addr] && !(hit0 || hit1);
   end

   reg_scoreboard #(
      .ADDR_W  (ADDR_W),
      .ZERO_R0 (ZERO_R0)
   ) u_scoreboard (
      .clk      (SYS_clk),
      .rst      (SYS_reset),
      .iss_en   (REG_iss_en),
      .iss_addr (REG_iss_addr),
      .wr_en0   (REG_wr_en0),
      .wr_addr0 (REG_wr_addr0),
      .wr_en1   (REG_wr_en1),
      .wr_addr1 (REG_wr_addr1),
      .pending  (pending),
      .busy_cnt (REG_busy_cnt)
   );

endmodule

// File: tb/tb_reg_file_param.sv
// Bench for reg_file_param: bypassing and non-bypassing instances checked every cycle against an array model.
module tb_reg_file_param;

   localparam int DW = 32;
   localparam int AW = 5;
   localparam int NR = 32;
   localparam int NP = 2;

   logic              SYS_clk = 1'b0;
   logic              SYS_reset;
   logic [NP*AW-1:0]  rd_addr;
   logic [NP*DW-1:0]  rd_data;
   logic [NP*DW-1:0]  rd_data_nb;
   logic [NP-1:0]     rd_busy;
   logic [NP-1:0]     rd_busy_nb;
   logic              we0;
   logic              we1;
   logic [AW-1:0]     wa0;
   logic [AW-1:0]     wa1;
   logic [DW-1:0]     wd0;
   logic [DW-1:0]     wd1;
   logic              iss_en;
   logic [AW-1:0]     iss_addr;
   logic [AW:0]       busy_cnt;
   logic [AW:0]       busy_cnt_nb;

   int n_checks = 0;
   int n_pass   = 0;
   bit chk_en   = 1'b0;

   logic [DW-1:0] m_mem  [NR];
   bit            m_pend [NR];

   always #5 SYS_clk = ~SYS_clk;

   reg_file_param u_dut (
      .SYS_clk      (SYS_clk),
      .SYS_reset    (SYS_reset),
      .REG_rd_addr  (rd_addr),
      .REG_rd_data  (rd_data),
      .REG_rd_busy  (rd_busy),
      .REG_wr_en0   (we0),
      .REG_wr_addr0 (wa0),
      .REG_wr_data0 (wd0),
      .REG_wr_en1   (we1),
      .REG_wr_addr1 (wa1),
      .REG_wr_data1 (wd1),
      .REG_iss_en   (iss_en),
      .REG_iss_addr (iss_addr),
      .REG_busy_cnt (busy_cnt)
   );

   reg_file_param #(.BYPASS(1'b0)) u_dut_nb (
      .SYS_clk      (SYS_clk),
      .SYS_reset    (SYS_reset),
      .REG_rd_addr  (rd_addr),
      .REG_rd_data  (rd_data_nb),
      .REG_rd_busy  (rd_busy_nb),
      .REG_wr_en0   (we0),
      .REG_wr_addr0 (wa0),
      .REG_wr_data0 (wd0),
      .REG_wr_en1   (we1),
      .REG_wr_addr1 (wa1),
      .REG_wr_data1 (wd1),
      .REG_iss_en   (iss_en),
      .REG_iss_addr (iss_addr),
      .REG_busy_cnt (busy_cnt_nb)
   );

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
   endtask

   // Reference model: sequential application of the write, clear and issue rules.
   always @(posedge SYS_clk) begin
      if (SYS_reset) begin
         foreach (m_mem[i]) begin
            m_mem[i]  = '0;
            m_pend[i] = 1'b0;
         end
      end else begin
         if (we0 && wa0 != '0) m_mem[wa0] = wd0;
         if (we1 && wa1 != '0) m_mem[wa1] = wd1;
         if (we0) m_pend[wa0] = 1'b0;
         if (we1) m_pend[wa1] = 1'b0;
         if (iss_en && iss_addr != '0) m_pend[iss_addr] = 1'b1;
      end
   end

   function automatic logic [DW-1:0] exp_data(input logic [AW-1:0] a, input bit byp);
      if (a == '0) return '0;
      if (byp && we1 && wa1 == a) return wd1;
      if (byp && we0 && wa0 == a) return wd0;
      return m_mem[a];
   endfunction

   function automatic logic exp_busy(input logic [AW-1:0] a, input bit byp);
      if (byp && ((we0 && wa0 == a) || (we1 && wa1 == a))) return 1'b0;
      return m_pend[a];
   endfunction

   function automatic int exp_cnt();
      int c = 0;
      foreach (m_pend[i]) c += int'(m_pend[i]);
      return c;
   endfunction

   function automatic logic [DW-1:0] port(input logic [NP*DW-1:0] v, input int k);
      return v[k*DW +: DW];
   endfunction

   always @(negedge SYS_clk) begin
      if (chk_en) begin
         for (int k = 0; k < NP; k++) begin
            logic [AW-1:0] a;
            a = rd_addr[k*AW +: AW];
            check($sformatf("model rd_data[%0d] bypass", k),   port(rd_data, k),    exp_data(a, 1'b1));
            check($sformatf("model rd_data[%0d] nobypass", k), port(rd_data_nb, k), exp_data(a, 1'b0));
            check($sformatf("model rd_busy[%0d] bypass", k),   DW'(rd_busy[k]),     DW'(exp_busy(a, 1'b1)));
            check($sformatf("model rd_busy[%0d] nobypass", k), DW'(rd_busy_nb[k]),  DW'(exp_busy(a, 1'b0)));
         end
         check("model busy_cnt bypass",   DW'(busy_cnt),    DW'(exp_cnt()));
         check("model busy_cnt nobypass", DW'(busy_cnt_nb), DW'(exp_cnt()));
      end
   end

   task automatic idle();
      we0 = 1'b0; wa0 = '0; wd0 = '0;
      we1 = 1'b0; wa1 = '0; wd1 = '0;
      iss_en = 1'b0; iss_addr = '0;
      rd_addr = '0;
   endtask

   task automatic set_rd(input int a0, input int a1);
      rd_addr = {AW'(a1), AW'(a0)};
   endtask

   task automatic next_cycle();
      @(posedge SYS_clk);
      #1;
   endtask

   function automatic logic [AW-1:0] rand_addr();
      if ($urandom_range(0, 3) == 0) return AW'($urandom_range(0, NR-1));
      return AW'($urandom_range(0, 7));
   endfunction

   initial begin
      idle();
      SYS_reset = 1'b1;
      next_cycle();
      chk_en = 1'b1;
      next_cycle();
      SYS_reset = 1'b0;

      // Post-reset sweep of every address on both ports.
      for (int a = 0; a < NR; a++) begin
         set_rd(a, NR-1-a);
         @(negedge SYS_clk);
         check("reset rd0 zero", port(rd_data, 0), 32'h0);
         check("reset rd1 zero", port(rd_data, 1), 32'h0);
         check("reset busy zero", DW'(rd_busy), 32'h0);
         check("reset cnt zero", DW'(busy_cnt), 32'h0);
         next_cycle();
      end

      // Same-address double write: port 1 wins, visible through bypass.
      idle();
      we0 = 1'b1; wa0 = 5; wd0 = 32'hDEAD_BEEF;
      we1 = 1'b1; wa1 = 5; wd1 = 32'h1234_5678;
      set_rd(5, 5);
      @(negedge SYS_clk);
      check("r5 bypass p0", port(rd_data, 0), 32'h1234_5678);
      check("r5 bypass p1", port(rd_data, 1), 32'h1234_5678);
      check("r5 nobypass old", port(rd_data_nb, 0), 32'h0);
      next_cycle();
      idle(); set_rd(5, 5);
      @(negedge SYS_clk);
      check("r5 stored", port(rd_data, 0), 32'h1234_5678);
      check("r5 stored nobypass", port(rd_data_nb, 1), 32'h1234_5678);
      next_cycle();

      // Register 0 ignores writes and issues.
      idle();
      we0 = 1'b1; wa0 = 0; wd0 = 32'hFFFF_FFFF;
      iss_en = 1'b1; iss_addr = 0;
      set_rd(0, 0);
      @(negedge SYS_clk);
      check("r0 bypass zero", port(rd_data, 0), 32'h0);
      next_cycle();
      idle(); set_rd(0, 0);
      @(negedge SYS_clk);
      check("r0 stored zero", port(rd_data, 1), 32'h0);
      check("r0 cnt zero", DW'(busy_cnt), 32'h0);
      next_cycle();

      // Scoreboard counting with issue/write collisions.
      idle(); iss_en = 1'b1; iss_addr = 3;
      next_cycle();
      idle(); iss_en = 1'b1; iss_addr = 7; set_rd(3, 7);
      @(negedge SYS_clk);
      check("sb cnt after r3", DW'(busy_cnt), 32'd1);
      check("sb busy r3", DW'(rd_busy), 32'b01);
      next_cycle();
      idle(); set_rd(3, 7);
      @(negedge SYS_clk);
      check("sb cnt after r7", DW'(busy_cnt), 32'd2);
      check("sb busy r3 r7", DW'(rd_busy), 32'b11);
      next_cycle();
      idle(); we0 = 1'b1; wa0 = 3; wd0 = 32'h0000_0333;
      iss_en = 1'b1; iss_addr = 3; set_rd(3, 7);
      @(negedge SYS_clk);
      check("sb busy r3 bypassed", DW'(rd_busy), 32'b10);
      check("sb busy r3 nobypass", DW'(rd_busy_nb), 32'b11);
      next_cycle();
      idle(); we0 = 1'b1; wa0 = 3; wd0 = 32'h0000_0033;
      we1 = 1'b1; wa1 = 7; wd1 = 32'h0000_0077; set_rd(3, 7);
      @(negedge SYS_clk);
      check("sb cnt set wins", DW'(busy_cnt), 32'd2);
      next_cycle();
      idle(); set_rd(3, 7);
      @(negedge SYS_clk);
      check("sb cnt drained", DW'(busy_cnt), 32'd0);
      check("sb r3 data", port(rd_data, 0), 32'h0000_0033);
      check("sb r7 data", port(rd_data, 1), 32'h0000_0077);
      next_cycle();

      // Non-bypassing instance returns the stored value during a write.
      idle(); iss_en = 1'b1; iss_addr = 9;
      next_cycle();
      idle(); we0 = 1'b1; wa0 = 9; wd0 = 32'hA5A5_A5A5; set_rd(9, 9);
      @(negedge SYS_clk);
      check("r9 nobypass old", port(rd_data_nb, 0), 32'h0);
      check("r9 nobypass busy", DW'(rd_busy_nb), 32'b11);
      check("r9 bypass new", port(rd_data, 0), 32'hA5A5_A5A5);
      next_cycle();
      idle(); set_rd(9, 9);
      @(negedge SYS_clk);
      check("r9 nobypass stored", port(rd_data_nb, 0), 32'hA5A5_A5A5);
      next_cycle();

      // Mid-operation reset with a concurrent write.
      for (int i = 1; i <= 4; i++) begin
         idle(); we0 = 1'b1; wa0 = AW'(i); wd0 = 32'h1000_0000 + i;
         iss_en = 1'b1; iss_addr = AW'(i);
         next_cycle();
      end
      idle(); set_rd(1, 4);
      @(negedge SYS_clk);
      check("pre-reset cnt", DW'(busy_cnt), 32'd4);
      check("pre-reset r1", port(rd_data, 0), 32'h1000_0001);
      check("pre-reset r4", port(rd_data, 1), 32'h1000_0004);
      next_cycle();
      idle(); SYS_reset = 1'b1; we0 = 1'b1; wa0 = 2; wd0 = 32'hBAD0_0002; set_rd(2, 2);
      next_cycle();
      SYS_reset = 1'b0; idle(); set_rd(1, 2);
      @(negedge SYS_clk);
      check("post-reset r1", port(rd_data, 0), 32'h0);
      check("post-reset r2", port(rd_data, 1), 32'h0);
      check("post-reset cnt", DW'(busy_cnt), 32'h0);
      check("post-reset busy", DW'(rd_busy), 32'h0);
      next_cycle();
      idle(); set_rd(3, 4);
      @(negedge SYS_clk);
      check("post-reset r3", port(rd_data, 0), 32'h0);
      check("post-reset r4", port(rd_data, 1), 32'h0);
      next_cycle();

      // Randomized traffic with address bias toward collisions and rare resets.
      for (int n = 0; n < 3000; n++) begin
         SYS_reset = ($urandom_range(0, 199) == 0);
         we0      = 1'($urandom_range(0, 1));
         wa0      = rand_addr();
         wd0      = $urandom();
         we1      = 1'($urandom_range(0, 1));
         wa1      = rand_addr();
         wd1      = $urandom();
         iss_en   = ($urandom_range(0, 2) != 0);
         iss_addr = rand_addr();
         rd_addr  = {rand_addr(), rand_addr()};
         next_cycle();
      end

      SYS_reset = 1'b0;
      idle();
      @(negedge SYS_clk);
      #1;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/reg_file_param.md
REG_FILE_PARAM -- requirements
Module: reg_file_param

Interface
REQ-001 Parameter DATA_W, default 32: register width in bits.
REQ-002 Parameter ADDR_W, default 5: address width; NUM_REGS = 2**ADDR_W.
REQ-003 Parameter NUM_RD, default 2: number of asynchronous read ports.
REQ-004 Parameter ZERO_R0, default 1: register 0 reads as zero, ignores writes and is never pending.
REQ-005 Parameter BYPASS, default 1: same-cycle write data is forwarded to the read ports.
REQ-006 SYS_clk  in  1  the only clock; all state updates on its rising edge.
REQ-007 SYS_reset  in  1  synchronous, active-high reset.
REQ-008 REG_rd_addr  in  NUM_RD*ADDR_W  read addresses; port k occupies bits [k*ADDR_W +: ADDR_W].
REQ-009 REG_rd_data  out  NUM_RD*DATA_W  read data; port k occupies bits [k*DATA_W +: DATA_W].
REQ-010 REG_rd_busy  out  NUM_RD  port k's addressed register is awaiting writeback.
REQ-011 REG_wr_en0 / REG_wr_en1  in  1 each  write enables for write ports 0 and 1.
REQ-012 REG_wr_addr0 / REG_wr_addr1  in  ADDR_W each  write addresses.
REQ-013 REG_wr_data0 / REG_wr_data1  in  DATA_W each  write data.
REQ-014 REG_iss_en  in  1  issue strobe; marks REG_iss_addr pending.
REQ-015 REG_iss_addr  in  ADDR_W  destination register of the issued instruction.
REQ-016 REG_busy_cnt  out  ADDR_W+1  number of registers currently pending.

Function
REQ-017 Writes: when REG_wr_enN=1, register[REG_wr_addrN] SHALL take REG_wr_dataN at the rising edge.
REQ-018 When both ports write the same address in one cycle, port 1 SHALL win.
REQ-019 Reads SHALL be combinational: REG_rd_data port k = register[addr_k].
REQ-020 With BYPASS=1, a read whose address matches an enabled write SHALL return that write's data in the same cycle, with port 1 taking priority over port 0; with BYPASS=0, the read SHALL return the stored value.
REQ-021 With ZERO_R0=1, reads of address 0 SHALL return 0, including the bypass path, and writes to address 0 SHALL be discarded.
REQ-022 Scoreboard: one pending bit per register; REG_iss_en=1 SHALL set pending[REG_iss_addr] at the edge.
REQ-023 An enabled write on either port SHALL clear pending[addr] at the edge.
REQ-024 When an issue and a write target the same address in the same cycle, set SHALL win and the bit stays pending.
REQ-025 With ZERO_R0=1, an issue to address 0 SHALL be ignored.
REQ-026 REG_rd_busy[k] = pending[addr_k] AND NOT (BYPASS=1 AND an enabled write matches addr_k this cycle).
REQ-027 REG_busy_cnt SHALL be registered and equal the population count of the pending bits after each edge, updated incrementally (+1 / -1 / -2 / 0) with no over- or underflow.
REQ-028 Issue and write of a register that is already pending or already clear SHALL not change REG_busy_cnt spuriously.

Reset
REQ-029 While SYS_reset=1 at a rising edge, all registers SHALL be cleared to 0, all pending bits to 0 and REG_busy_cnt to 0; reset SHALL override writes and issues in that cycle.
REQ-030 In the cycle after reset deasserts, REG_rd_data=0, REG_rd_busy=0 and REG_busy_cnt=0 on every port, absent bypass.
REQ-031 Reset asserted mid-operation SHALL discard all pending state; no write SHALL land in that cycle.

Structure
REQ-032 A shared package SHALL hold the DATA_W/ADDR_W defaults and a popcount-delta function; no typedefs beyond these.
REQ-033 One sub-module, reg_scoreboard, SHALL contain the pending bits and REG_busy_cnt; the storage array and read/bypass muxing SHALL stay in the top level.

Verification
REQ-034 Reset, then read all 32 addresses on both ports -> every data word is 0, REG_rd_busy=0, REG_busy_cnt=0.
REQ-035 Write port0 r5=0xDEADBEEF and port1 r5=0x12345678 in the same cycle, with read r5 in that cycle -> reads 0x12345678 in that cycle (bypass) and on the next cycle.
REQ-036 Write r0=0xFFFFFFFF and issue r0 -> read r0=0, REG_busy_cnt stays 0.
REQ-037 Issue r3, then r7 -> REG_busy_cnt=2 and busy on r3; next, write r3 with a same-cycle issue of r3 -> REG_busy_cnt stays 2; next, write r3 and r7 -> REG_busy_cnt=0.
REQ-038 Build with BYPASS=0: write r9=0xA5A5A5A5 while reading r9 -> old value 0 and REG_rd_busy reflects pending[9]; next cycle -> 0xA5A5A5A5.
REQ-039 With r1..r4 pending and data written, assert SYS_reset for one cycle with a concurrent write to r2 -> all registers read 0 and REG_busy_cnt=0.
